// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer: slot geometry, link
// state encoding and the per-sample action decode used by the top.
package tdm_demux4_pkg;

  localparam int unsigned NSLOT  = 4;
  localparam int unsigned SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t SLOT_FIRST = '0;
  localparam slot_t SLOT_LAST  = slot_t'(NSLOT - 1);

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_START,
    ACT_STORE,
    ACT_LOSE
  } act_e;

  typedef struct packed {
    act_e kind;
    logic err;
  } slot_act_t;

  // Decide what one input cycle does to the frame under construction.
  // A marker at slot 0 while locked is an ordinary frame start.
  function automatic slot_act_t slot_action(
    input state_e st,
    input logic   en,
    input logic   frame,
    input slot_t  sel
  );
    slot_act_t a;
    a.kind = ACT_IDLE;
    a.err  = 1'b0;
    if (en) begin
      if (st == HUNT) begin
        if (frame) a.kind = ACT_START;
      end else if (frame) begin
        a.kind = ACT_START;
        a.err  = (sel != SLOT_FIRST);
      end else if (sel == SLOT_FIRST) begin
        a.kind = ACT_LOSE;
        a.err  = 1'b1;
      end else begin
        a.kind = ACT_STORE;
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// Modulo-4 slot counter: clear beats load-to-1, which beats increment.
// wrap_o flags an increment out of the last slot.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc_i,
  input  logic  load1_i,
  input  logic  clr_i,
  output slot_t cnt_o,
  output logic  wrap_o
);

  slot_t cnt_q;
  slot_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = slot_t'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i && !load1_i && !clr_i && (cnt_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 TDM link: hunts for the frame marker, steers slots
// into shadow registers and publishes each complete frame with a valid pulse.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         frame,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [1:0]   sel,
  output logic         valid,
  output logic         locked,
  output logic         sync_err
);

  state_e    state_q, state_d;
  slot_act_t act;
  slot_t     cnt;
  logic      wrap;
  logic      ctr_inc, ctr_load1, ctr_clr;

  logic [W-1:0] sh0_q, sh0_d;
  logic [W-1:0] sh1_q, sh1_d;
  logic [W-1:0] sh2_q, sh2_d;
  logic [W-1:0] last_q, last_d;
  logic         load_q, load_d;
  logic         err_q, err_d;

  logic [W-1:0] y0_q, y0_d;
  logic [W-1:0] y1_q, y1_d;
  logic [W-1:0] y2_q, y2_d;
  logic [W-1:0] y3_q, y3_d;
  logic         valid_q, valid_d;
  logic         locked_q, locked_d;
  logic         sync_err_q, sync_err_d;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (ctr_inc),
    .load1_i (ctr_load1),
    .clr_i   (ctr_clr),
    .cnt_o   (cnt),
    .wrap_o  (wrap)
  );

  always_comb begin
    act        = slot_action(state_q, en, frame, cnt);
    state_d    = state_q;
    ctr_inc    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_clr    = 1'b0;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    last_d     = last_q;
    load_d     = 1'b0;
    err_d      = act.err;

    // Output bank runs one cycle behind acceptance, so a new frame's slot 0
    // may overwrite sh0 on the same edge that publishes the old one.
    y0_d       = y0_q;
    y1_d       = y1_q;
    y2_d       = y2_q;
    y3_d       = y3_q;
    valid_d    = load_q;
    sync_err_d = err_q;
    if (load_q) begin
      y0_d = sh0_q;
      y1_d = sh1_q;
      y2_d = sh2_q;
      y3_d = last_q;
    end

    case (act.kind)
      ACT_START: begin
        sh0_d     = din;
        ctr_load1 = 1'b1;
        state_d   = SYNC;
      end
      ACT_STORE: begin
        ctr_inc = 1'b1;
        case (cnt)
          2'd1:    sh1_d = din;
          2'd2:    sh2_d = din;
          2'd3:    last_d = din;
          default: sh0_d = din;
        endcase
        load_d = wrap;
      end
      ACT_LOSE: begin
        ctr_clr = 1'b1;
        state_d = HUNT;
      end
      default: begin
        ctr_clr = (state_q == HUNT);
      end
    endcase

    locked_d = (state_d == SYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sh0_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      last_q     <= '0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      y0_q       <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      y3_q       <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      last_q     <= last_d;
      load_q     <= load_d;
      err_q      <= err_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      y2_q       <= y2_d;
      y3_q       <= y3_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign y0       = y0_q;
  assign y1       = y1_q;
  assign y2       = y2_q;
  assign y3       = y3_q;
  assign sel      = cnt;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=1): stimulus pushes hand-computed frame and
// error events into a queue; a negedge monitor checks each DUT pulse and y hold.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       frame = 1'b0;
  logic       y0, y1, y2, y3;
  logic [1:0] sel;
  logic       valid, locked, sync_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    bit         is_err;
    int         at;
    logic [3:0] y;
  } exp_t;

  exp_t       q[$];
  logic [3:0] y_hold = 4'b0;

  tdm_demux4 #(.W(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .frame    (frame),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .sel      (sel),
    .valid    (valid),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of input; returns #1 after the edge that sampled it.
  task automatic step(input logic e, input logic f, input logic d);
    en = e;
    frame = f;
    din = d;
    @(posedge clk);
    #1;
    en = 1'b0;
    frame = 1'b0;
    din = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_valid(input logic a, input logic b, input logic c, input logic d);
    exp_t e;
    e.is_err = 1'b0;
    e.at = cyc + 1;
    e.y = {d, c, b, a};
    q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1;
    e.at = cyc + 1;
    e.y = 4'b0;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [3:0] ya;
    ya = {y3, y2, y1, y0};
    if (!rst_n) begin
      y_hold = 4'b0;
    end else if (valid === 1'b1 || sync_err === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: valid=%0b sync_err=%0b want no pulse (cycle %0d)",
                 valid, sync_err, cyc);
      end else begin
        e = q.pop_front();
        chk("event_valid", {31'b0, valid}, {31'b0, !e.is_err});
        chk("event_sync_err", {31'b0, sync_err}, {31'b0, e.is_err});
        chk("event_cycle", cyc, e.at);
        if (!e.is_err) begin
          chk("y_frame", {28'b0, ya}, {28'b0, e.y});
          y_hold = e.y;
        end else begin
          chk("y_hold_on_err", {28'b0, ya}, {28'b0, y_hold});
        end
      end
    end else begin
      chk("y_hold", {28'b0, ya}, {28'b0, y_hold});
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_y"}, {28'b0, y3, y2, y1, y0}, 32'h0);
    chk({tag, "_sel"}, {30'b0, sel}, 32'h0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
    chk({tag, "_locked"}, {31'b0, locked}, 32'h0);
    chk({tag, "_sync_err"}, {31'b0, sync_err}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    // Basic frame 1,0,1,1
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
    exp_valid(1, 0, 1, 1);
    chk("locked_after_frame", {31'b0, locked}, 32'h1);
    chk("sel_after_slot3", {30'b0, sel}, 32'h0);

    // Back-to-back frames, marker right after slot 3
    step(1, 1, 0); step(1, 0, 1); step(1, 0, 1); step(1, 0, 0);
    exp_valid(0, 1, 1, 0);
    step(1, 1, 1); step(1, 0, 1); step(1, 0, 0); step(1, 0, 0);
    exp_valid(1, 1, 0, 0);
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    exp_valid(0, 0, 0, 1);
    idle(2);

    // Early marker at sel=2
    step(1, 1, 1); step(1, 0, 1);
    chk("sel_before_early", {30'b0, sel}, 32'h2);
    step(1, 1, 0);
    exp_err();
    chk("sel_after_early", {30'b0, sel}, 32'h1);
    chk("locked_after_early", {31'b0, locked}, 32'h1);
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 0);
    exp_valid(0, 1, 1, 0);
    idle(1);

    // Early marker on slot 3 position
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1);
    step(1, 1, 1);
    exp_err();
    chk("sel_after_slot3_marker", {30'b0, sel}, 32'h1);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    exp_valid(1, 0, 0, 1);
    idle(1);

    // Missing marker at sel=0
    step(1, 0, 1);
    exp_err();
    chk("locked_after_missing", {31'b0, locked}, 32'h0);
    chk("sel_after_missing", {30'b0, sel}, 32'h0);
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    chk("locked_while_hunting", {31'b0, locked}, 32'h0);
    chk("sel_while_hunting", {30'b0, sel}, 32'h0);
    idle(2);

    // en toggling across one frame; marker with en=0 must be ignored
    step(1, 1, 1); step(0, 0, 0); step(1, 0, 1); step(0, 1, 0);
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 1);
    exp_valid(1, 1, 0, 1);
    idle(3);

    // Reset after slot 1 of a frame
    step(1, 1, 0); step(1, 0, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    chk_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    step(1, 0, 1);
    chk("locked_needs_marker", {31'b0, locked}, 32'h0);
    step(1, 1, 0); step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    exp_valid(0, 1, 0, 1);
    idle(3);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("events_drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
